// File: rtl/stopwatch_lap_pkg.sv
// Shared field widths, limits, FSM encoding and packing order for the stopwatch core.
// A packed time value is {hours, minutes, seconds, milliseconds}, hours in the MSBs.
package stopwatch_lap_pkg;

    localparam int MS_W       = 10;
    localparam int S_W        = 6;
    localparam int M_W        = 6;
    localparam int SUB_HOUR_W = M_W + S_W + MS_W;

    localparam logic [MS_W-1:0] MS_MAX = 10'd999;
    localparam logic [S_W-1:0]  SM_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    // Lower 22 bits of a packed time; the hours field width is a top-level parameter.
    typedef struct packed {
        logic [M_W-1:0]  m;
        logic [S_W-1:0]  s;
        logic [MS_W-1:0] ms;
    } sub_hour_t;

    function automatic sub_hour_t sat_sub_hour(input sub_hour_t v);
        sub_hour_t r;
        r    = v;
        r.m  = (v.m  > SM_MAX) ? SM_MAX : v.m;
        r.s  = (v.s  > SM_MAX) ? SM_MAX : v.s;
        r.ms = (v.ms > MS_MAX) ? MS_MAX : v.ms;
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured lap times.
// Head reads as zero while empty; a push into a full FIFO only lands if a pop frees a slot.
module lap_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage has no reset; the zero-count guard on o_data hides stale contents.
    always_ff @(posedge Clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Stopwatch/timer core: up or countdown binary H:M:S.ms counters advanced by a 1 ms tick,
// preset load with per-field saturation, and a lap-capture FIFO.
module stopwatch_lap
    import stopwatch_lap_pkg::*;
#(
    parameter int HOURS_W   = 4,
    parameter int HOURS_MAX = 9,
    parameter int LAP_DEPTH = 8,
    parameter int TIME_W    = HOURS_W + SUB_HOUR_W
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Tick_1MSec,
    input  logic                         Start_S,
    input  logic                         Stop_S,
    input  logic                         Reset_S,
    input  logic                         Mode,
    input  logic                         Load_S,
    input  logic [TIME_W-1:0]            Preset_Time,
    input  logic                         Lap_S,
    input  logic                         Lap_Rd,
    output logic [HOURS_W-1:0]           Hours_S,
    output logic [M_W-1:0]               Mins_S,
    output logic [S_W-1:0]               Secs_S,
    output logic [MS_W-1:0]              MSecs_S,
    output logic                         Running,
    output logic                         Done,
    output logic                         Wrap,
    output logic                         Lap_Valid,
    output logic [TIME_W-1:0]            Lap_Time,
    output logic [$clog2(LAP_DEPTH):0]   Lap_Count,
    output logic                         Lap_Ovf
);

    localparam logic [HOURS_W-1:0] H_MAX = HOURS_W'(HOURS_MAX);

    state_t               r_state;
    logic                 r_mode;
    logic                 r_running;
    logic                 r_done;
    logic                 r_wrap;
    logic                 r_ovf;
    logic [HOURS_W-1:0]   r_hours;
    sub_hour_t            r_time;

    logic [HOURS_W-1:0]   w_preset_h;
    sub_hour_t            w_preset_sub;
    logic [HOURS_W-1:0]   w_up_h;
    sub_hour_t            w_up_sub;
    logic [HOURS_W-1:0]   w_dn_h;
    sub_hour_t            w_dn_sub;
    logic                 w_is_zero;
    logic                 w_at_max;
    logic                 w_dn_last;
    logic                 w_start_ok;
    logic                 w_fifo_empty;
    logic                 w_fifo_full;

    always_comb begin
        w_preset_h   = Preset_Time[TIME_W-1 -: HOURS_W];
        w_preset_sub = sat_sub_hour(Preset_Time[SUB_HOUR_W-1:0]);
        if (w_preset_h > H_MAX) w_preset_h = H_MAX;
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        w_up_h      = r_hours;
        w_up_sub    = r_time;
        w_up_sub.ms = r_time.ms + 1'b1;
        if (r_time.ms == MS_MAX) begin
            w_up_sub.ms = '0;
            w_up_sub.s  = r_time.s + 1'b1;
            if (r_time.s == SM_MAX) begin
                w_up_sub.s = '0;
                w_up_sub.m = r_time.m + 1'b1;
                if (r_time.m == SM_MAX) begin
                    w_up_sub.m = '0;
                    w_up_h     = (r_hours == H_MAX) ? '0 : r_hours + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_dn_h      = r_hours;
        w_dn_sub    = r_time;
        w_dn_sub.ms = r_time.ms - 1'b1;
        if (r_time.ms == '0) begin
            w_dn_sub.ms = MS_MAX;
            w_dn_sub.s  = r_time.s - 1'b1;
            if (r_time.s == '0) begin
                w_dn_sub.s = SM_MAX;
                w_dn_sub.m = r_time.m - 1'b1;
                if (r_time.m == '0) begin
                    w_dn_sub.m = SM_MAX;
                    w_dn_h     = r_hours - 1'b1;
                end
            end
        end
    end

    assign w_is_zero = (r_hours == '0) && (r_time == '0);
    assign w_at_max  = (r_hours == H_MAX) && (r_time.m == SM_MAX) &&
                       (r_time.s == SM_MAX) && (r_time.ms == MS_MAX);
    assign w_dn_last = (r_hours == '0) && (r_time.m == '0) && (r_time.s == '0) &&
                       (r_time.ms == MS_W'(1));
    // Start is honoured only when it is not overridden by a load or stop in the same cycle.
    assign w_start_ok = Start_S && !Stop_S && !Load_S;

    // NOTE: sequential state uses non-blocking assignments; later assignments in the block win.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_ovf     <= 1'b0;
            r_hours   <= '0;
            r_time    <= '0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (Reset_S) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_ovf     <= 1'b0;
                r_hours   <= '0;
                r_time    <= '0;
            end else begin
                if (Lap_S && w_fifo_full && !Lap_Rd) r_ovf <= 1'b1;

                case (r_state)
                    ST_IDLE: begin
                        if (w_start_ok) begin
                            r_mode <= Mode;
                            if (!(Mode && w_is_zero)) begin
                                r_state   <= ST_RUN;
                                r_running <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (w_start_ok && !(r_mode && w_is_zero)) begin
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (Stop_S) begin
                            r_state   <= ST_PAUSED;
                            r_running <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                    end
                endcase

                if (Load_S && r_state != ST_RUN) begin
                    r_hours <= w_preset_h;
                    r_time  <= w_preset_sub;
                end else if (r_state == ST_RUN && Tick_1MSec) begin
                    if (!r_mode) begin
                        r_hours <= w_up_h;
                        r_time  <= w_up_sub;
                        r_wrap  <= w_at_max;
                    end else begin
                        r_hours <= w_dn_h;
                        r_time  <= w_dn_sub;
                        if (w_dn_last) begin
                            r_done    <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_running <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_flush (Reset_S),
        .i_push  (Lap_S),
        .i_pop   (Lap_Rd),
        .i_data  ({r_hours, r_time}),
        .o_data  (Lap_Time),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_count (Lap_Count)
    );

    assign Hours_S   = r_hours;
    assign Mins_S    = r_time.m;
    assign Secs_S    = r_time.s;
    assign MSecs_S   = r_time.ms;
    assign Running   = r_running;
    assign Done      = r_done;
    assign Wrap      = r_wrap;
    assign Lap_Ovf   = r_ovf;
    assign Lap_Valid = !w_fifo_empty;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Self-checking bench for stopwatch_lap: directed table, corner sequences and a
// randomized run against a millisecond-total reference model.
module tb_stopwatch_lap;

    localparam int HOURS_W   = 4;
    localparam int HOURS_MAX = 9;
    localparam int LAP_DEPTH = 8;
    localparam int TIME_W    = HOURS_W + 22;
    localparam int PERIOD    = (HOURS_MAX + 1) * 3600000;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;

    logic              Clock;
    logic              Reset;
    logic              Tick_1MSec;
    logic              Start_S;
    logic              Stop_S;
    logic              Reset_S;
    logic              Mode;
    logic              Load_S;
    logic [TIME_W-1:0] Preset_Time;
    logic              Lap_S;
    logic              Lap_Rd;
    logic [HOURS_W-1:0] Hours_S;
    logic [5:0]        Mins_S;
    logic [5:0]        Secs_S;
    logic [9:0]        MSecs_S;
    logic              Running;
    logic              Done;
    logic              Wrap;
    logic              Lap_Valid;
    logic [TIME_W-1:0] Lap_Time;
    logic [3:0]        Lap_Count;
    logic              Lap_Ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_state;
    int m_total;
    bit m_mode;
    bit m_ovf;
    bit m_done;
    bit m_wrap;
    int m_q[$];

    stopwatch_lap #(
        .HOURS_W   (HOURS_W),
        .HOURS_MAX (HOURS_MAX),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Tick_1MSec  (Tick_1MSec),
        .Start_S     (Start_S),
        .Stop_S      (Stop_S),
        .Reset_S     (Reset_S),
        .Mode        (Mode),
        .Load_S      (Load_S),
        .Preset_Time (Preset_Time),
        .Lap_S       (Lap_S),
        .Lap_Rd      (Lap_Rd),
        .Hours_S     (Hours_S),
        .Mins_S      (Mins_S),
        .Secs_S      (Secs_S),
        .MSecs_S     (MSecs_S),
        .Running     (Running),
        .Done        (Done),
        .Wrap        (Wrap),
        .Lap_Valid   (Lap_Valid),
        .Lap_Time    (Lap_Time),
        .Lap_Count   (Lap_Count),
        .Lap_Ovf     (Lap_Ovf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [TIME_W-1:0] to_fields(input int t);
        logic [3:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic [9:0] ms;
        ms = 10'(t % 1000);
        s  = 6'((t / 1000) % 60);
        m  = 6'((t / 60000) % 60);
        h  = 4'(t / 3600000);
        return {h, m, s, ms};
    endfunction

    function automatic int sat_total(input logic [TIME_W-1:0] p);
        int h, m, s, ms;
        h  = int'(p[25:22]);
        m  = int'(p[21:16]);
        s  = int'(p[15:10]);
        ms = int'(p[9:0]);
        if (h > HOURS_MAX) h = HOURS_MAX;
        if (m > 59) m = 59;
        if (s > 59) s = 59;
        if (ms > 999) ms = 999;
        return ((h * 60 + m) * 60 + s) * 1000 + ms;
    endfunction

    function automatic logic [TIME_W-1:0] now_time();
        return {Hours_S, Mins_S, Secs_S, MSecs_S};
    endfunction

    // One clock edge; outputs are sampled 1 ns later, then all pulse inputs drop.
    task automatic step();
        @(posedge Clock);
        #1;
        Tick_1MSec = 1'b0;
        Start_S    = 1'b0;
        Stop_S     = 1'b0;
        Reset_S    = 1'b0;
        Load_S     = 1'b0;
        Lap_S      = 1'b0;
        Lap_Rd     = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            Tick_1MSec = 1'b1;
            step();
        end
    endtask

    task automatic model_step();
        int nxt;
        m_done = 1'b0;
        m_wrap = 1'b0;
        if (Reset_S) begin
            m_state = S_IDLE;
            m_total = 0;
            m_ovf   = 1'b0;
            m_q.delete();
            return;
        end
        if (Lap_S && m_q.size() == LAP_DEPTH && !Lap_Rd) m_ovf = 1'b1;
        if (Lap_Rd && m_q.size() > 0) void'(m_q.pop_front());
        if (Lap_S && m_q.size() < LAP_DEPTH) m_q.push_back(m_total);

        nxt = m_state;
        if (Load_S && m_state != S_RUN) begin
            m_total = sat_total(Preset_Time);
        end else if (m_state == S_RUN && Tick_1MSec) begin
            if (!m_mode) begin
                m_total = (m_total + 1) % PERIOD;
                m_wrap  = (m_total == 0);
            end else begin
                m_total = m_total - 1;
                m_done  = (m_total == 0);
            end
        end
        if (!Load_S && Start_S && !Stop_S && m_state == S_IDLE) begin
            m_mode = Mode;
            if (!(Mode && m_total == 0)) nxt = S_RUN;
        end else if (!Load_S && Start_S && !Stop_S && m_state == S_PAUSED &&
                     !(m_mode && m_total == 0)) begin
            nxt = S_RUN;
        end else if (m_state == S_RUN && Stop_S) begin
            nxt = S_PAUSED;
        end
        if (m_done) nxt = S_IDLE;
        m_state = nxt;
    endtask

    typedef struct {
        string             name;
        bit                rs;
        bit                ld;
        bit                start;
        bit                stop;
        bit                mode;
        logic [TIME_W-1:0] preset;
        int                n_ticks;
        int                exp_total;
        bit                exp_run;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{"sync_reset",      1, 0, 0, 0, 0, '0,                         0,    0,        0};
        vecs[1]  = '{"start_1500",      0, 0, 1, 0, 0, '0,                         1500, 1500,     1};
        vecs[2]  = '{"stop",            0, 0, 0, 1, 0, '0,                         0,    1500,     0};
        vecs[3]  = '{"paused_ticks",    0, 0, 0, 0, 0, '0,                         200,  1500,     0};
        vecs[4]  = '{"resume",          0, 0, 1, 0, 0, '0,                         10,   1510,     1};
        vecs[5]  = '{"load_in_run",     0, 1, 0, 0, 0, {4'd5, 6'd0, 6'd0, 10'd0},  0,    1510,     1};
        vecs[6]  = '{"start_stop_run",  0, 0, 1, 1, 0, '0,                         0,    1510,     0};
        vecs[7]  = '{"load_paused",     0, 1, 0, 0, 0, {4'd3, 6'd25, 6'd7, 10'd42}, 0,   12307042, 0};
        vecs[8]  = '{"load_saturate",   0, 1, 0, 0, 0, {4'd15, 6'd63, 6'd60, 10'd1023}, 0, PERIOD - 1, 0};
        vecs[9]  = '{"resume_wrap",     0, 0, 1, 0, 0, '0,                         1,    0,        1};
        vecs[10] = '{"reset_s_run",     1, 0, 0, 0, 0, '0,                         5,    0,        0};
        vecs[11] = '{"start_stop_idle", 0, 0, 1, 1, 0, '0,                         5,    0,        0};
        vecs[12] = '{"down_zero_start", 0, 0, 1, 0, 1, '0,                         3,    0,        0};
        vecs[13] = '{"load_beats_start", 0, 1, 1, 0, 0, {4'd0, 6'd0, 6'd2, 10'd0}, 4,    2000,     0};

        Reset = 1'b1;
        Tick_1MSec = 1'b0; Start_S = 1'b0; Stop_S = 1'b0; Reset_S = 1'b0;
        Mode = 1'b0; Load_S = 1'b0; Preset_Time = '0; Lap_S = 1'b0; Lap_Rd = 1'b0;
        #3;
        check("reset_outputs",
              {now_time(), Running, Done, Wrap, Lap_Valid, Lap_Time, Lap_Count, Lap_Ovf}, '0);
        #9;
        Reset = 1'b0;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            Reset_S     = vecs[i].rs;
            Load_S      = vecs[i].ld;
            Start_S     = vecs[i].start;
            Stop_S      = vecs[i].stop;
            Mode        = vecs[i].mode;
            Preset_Time = vecs[i].preset;
            step();
            ticks(vecs[i].n_ticks);
            check({vecs[i].name, "_time"}, now_time(), to_fields(vecs[i].exp_total));
            check({vecs[i].name, "_running"}, Running, vecs[i].exp_run);
        end

        // Up-count rollover: Wrap only on the rolling tick
        Reset_S = 1'b1; step();
        Mode = 1'b0; Load_S = 1'b1; Preset_Time = {4'd9, 6'd59, 6'd59, 10'd998}; step();
        Start_S = 1'b1; step();
        ticks(1);
        check("wrap_pre_time", now_time(), to_fields(PERIOD - 1));
        check("wrap_pre_flag", Wrap, 1'b0);
        ticks(1);
        check("wrap_time", now_time(), '0);
        check("wrap_flag", {Wrap, Running}, 2'b11);
        step();
        check("wrap_pulse_end", Wrap, 1'b0);

        // Countdown to zero
        Reset_S = 1'b1; step();
        Mode = 1'b1; Load_S = 1'b1; Preset_Time = {4'd0, 6'd0, 6'd1, 10'd0}; step();
        Start_S = 1'b1; step();
        ticks(999);
        check("down_pre_time", now_time(), to_fields(1));
        check("down_pre_flags", {Done, Running}, 2'b01);
        ticks(1);
        check("down_time", now_time(), '0);
        check("down_flags", {Done, Running}, 2'b10);
        step();
        check("done_pulse_end", Done, 1'b0);
        Start_S = 1'b1; step();
        check("down_zero_restart", {Done, Running}, 2'b00);

        // Lap capture with overflow, then drain in order
        Reset_S = 1'b1; step();
        Mode = 1'b0; Start_S = 1'b1; step();
        for (int t = 1; t <= 45; t++) begin
            ticks(1);
            if (t % 5 == 0) begin
                Lap_S = 1'b1;
                step();
            end
        end
        Stop_S = 1'b1; step();
        check("lap_count_full", Lap_Count, 4'd8);
        check("lap_ovf_set", {Lap_Ovf, Lap_Valid}, 2'b11);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("lap_pop_%0d", i), Lap_Time, to_fields(5 * i));
            Lap_Rd = 1'b1;
            step();
        end
        check("lap_drained", {Lap_Valid, Lap_Count}, '0);
        check("lap_empty_time", Lap_Time, '0);
        Lap_Rd = 1'b1; step();
        check("lap_empty_pop", {Lap_Valid, Lap_Count, Lap_Ovf}, {1'b0, 4'd0, 1'b1});

        // Asynchronous reset mid-count with laps held
        Reset_S = 1'b1; step();
        Start_S = 1'b1; step();
        ticks(7);
        for (int i = 0; i < 3; i++) begin
            Lap_S = 1'b1; Tick_1MSec = 1'b1; step();
        end
        check("pre_async_laps", Lap_Count, 4'd3);
        Tick_1MSec = 1'b1;
        @(posedge Clock);
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {now_time(), Running, Done, Wrap, Lap_Valid, Lap_Time, Lap_Count, Lap_Ovf}, '0);
        #3;
        Reset = 1'b0;
        step();
        check("after_async_idle", {now_time(), Running}, '0);

        // Randomized run against the reference model
        Reset_S = 1'b1;
        model_step();
        step();
        m_mode = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            Tick_1MSec = ($urandom_range(0, 99) < 70);
            Start_S    = ($urandom_range(0, 99) < 6);
            Stop_S     = ($urandom_range(0, 99) < 3);
            Load_S     = ($urandom_range(0, 99) < 4);
            Reset_S    = ($urandom_range(0, 199) == 0);
            Lap_S      = ($urandom_range(0, 99) < 10);
            Lap_Rd     = ($urandom_range(0, 99) < 8);
            Mode       = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       Preset_Time = to_fields(int'($urandom_range(0, 60)));
                1:       Preset_Time = to_fields(PERIOD - 1 - int'($urandom_range(0, 60)));
                default: Preset_Time = TIME_W'($urandom);
            endcase
            model_step();
            step();
            check("rand_time", now_time(), to_fields(m_total));
            check("rand_flags", {Running, Done, Wrap, Lap_Valid, Lap_Ovf, Lap_Count},
                  {m_state == S_RUN, m_done, m_wrap, m_q.size() > 0, m_ovf, 4'(m_q.size())});
            check("rand_lap_time", Lap_Time, (m_q.size() > 0) ? to_fields(m_q[0]) : '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
